// File: rtl/avg_unpool_stream.sv
// avg_unpool_stream
//   Streaming 2x2 unpooling (upsampler). Accepts an (InputH/2)x(InputW/2)
//   map, one pixel per handshake in raster order, and emits the
//   InputH x InputW map in raster order, each input pixel covering its
//   2x2 output window.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   in_valid   / in_ready / in_data    pooled pixel stream (input side)
//   out_valid  / out_ready / out_data  upsampled pixel stream (output side)
//   out_last   high with the final pixel of a frame
//
// Build option:
//   UNPOOL_ZERO_FILL_EN  defined   -> zero-insertion unpooling (only the top
//                                     left pixel of each window carries data,
//                                     no line buffer)
//                        undefined -> nearest-neighbour replication
module avg_unpool_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int InputH     = 28,
    parameter int InputW     = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int HalfW = InputW / 2;
    localparam int HalfH = InputH / 2;
    localparam int ColW  = (HalfW > 1) ? $clog2(HalfW) : 1;
    localparam int RowW  = (HalfH > 1) ? $clog2(HalfH) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(HalfW - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(HalfH - 1);

    typedef enum logic {
        ROW_EVEN,
        ROW_ODD
    } state_t;

    state_t          state;
    logic [ColW-1:0] col;
    logic [ColW-1:0] advCol;
    logic [RowW-1:0] prow;
    logic            dup;

    logic colLast;
    logic rowLast;
    logic outXfer;
    logic copyDone;
    logic inXfer;

    logic [DATA_WIDTH-1:0] oddData;
    logic [DATA_WIDTH-1:0] dupData;

    assign colLast  = (col == LastCol);
    assign rowLast  = (prow == LastRow);
    assign outXfer  = out_valid & out_ready;
    assign copyDone = outXfer & dup;
    assign advCol   = colLast ? '0 : col + 1'b1;

    // Input is taken while the holding register frees up, except at the end
    // of an even row (the slot goes to the odd-row replay). The final copy of
    // an odd row also frees the slot, so the next even row (or next frame)
    // starts without a bubble.
    always_comb begin
        in_ready = 1'b0;
        if (reset) begin
            unique case (state)
                ROW_EVEN: in_ready = !out_valid || (copyDone && !colLast);
                ROW_ODD:  in_ready = copyDone && colLast;
            endcase
        end
    end

    assign inXfer = in_valid & in_ready;

`ifdef UNPOOL_ZERO_FILL_EN
    assign oddData = '0;
    assign dupData = '0;
`else
    logic [DATA_WIDTH-1:0] lineBuf [HalfW];
    logic [ColW-1:0]       nextCol;

    // col names the entry in the holding register; once its second copy
    // leaves, the next write/read targets the following column.
    assign nextCol = copyDone ? advCol : col;
    assign oddData = lineBuf[nextCol];
    assign dupData = out_data;

    always_ff @(posedge clk) begin
        if (inXfer) begin
            lineBuf[nextCol] <= in_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ROW_EVEN;
            col       <= '0;
            prow      <= '0;
            dup       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (copyDone) begin
                col <= advCol;
            end
            unique case (state)
                ROW_EVEN: begin
                    if (inXfer) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        dup       <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (copyDone) begin
                        dup      <= 1'b0;
                        out_last <= 1'b0;
                        if (colLast) begin
                            // Preload the first replay entry so the odd row
                            // follows with no idle cycle.
                            state     <= ROW_ODD;
                            out_data  <= oddData;
                            out_valid <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end else if (outXfer) begin
                        dup      <= 1'b1;
                        out_data <= dupData;
                    end
                end
                ROW_ODD: begin
                    if (copyDone && colLast) begin
                        state    <= ROW_EVEN;
                        prow     <= rowLast ? '0 : prow + 1'b1;
                        dup      <= 1'b0;
                        out_last <= 1'b0;
                        if (inXfer) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                        end else begin
                            out_valid <= 1'b0;
                        end
                    end else if (copyDone || !out_valid) begin
                        out_data  <= oddData;
                        out_valid <= 1'b1;
                        dup       <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (outXfer) begin
                        dup      <= 1'b1;
                        out_data <= dupData;
                        out_last <= colLast && rowLast;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/avg_unpool_stream.md
Name: avg_unpool_stream

Overview:
- Streaming 2x2 nearest-neighbour unpooling (upsampler), the inverse-direction counterpart of the 2x2 average-pooling stage.
- Accepts a (InputH/2)x(InputW/2) feature map, one pixel per handshake in raster order, and emits the InputH x InputW map in raster order.
- Each input pixel is replicated into its 2x2 output window.
- Sits between a pooled-feature producer and any consumer that needs full-resolution maps, e.g. a reconstruction or backprop path.

Parameters:
- DATA_WIDTH, 16, bits per pixel; treated as opaque, no arithmetic.
- InputH, 28, output map height; must be even.
- InputW, 28, output map width; must be even.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge, asserted when 0.
- in_valid  input  1  input pixel valid.
- in_ready  output  1  block can accept an input pixel this cycle.
- in_data  input  DATA_WIDTH  pooled pixel, raster order.
- out_valid  output  1  out_data holds a valid pixel.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  DATA_WIDTH  upsampled pixel, raster order.
- out_last  output  1  high with the final pixel of a frame (row InputH-1, col InputW-1).

Behaviour:
- Transfers: an input transfer occurs when in_valid and in_ready are both 1; an output transfer when out_valid and out_ready are both 1.
- Storage:
  - Line buffer of InputW/2 entries x DATA_WIDTH.
  - Output holding register (out_data, out_valid, out_last) plus a 1-bit dup flag: 0 = first copy, 1 = second copy.
- Counters: col 0..InputW/2-1, prow (pooled row) 0..InputH/2-1.
- FSM states:
  - ROW_EVEN: output rows 0,2,4,...; consumes the input stream.
  - ROW_ODD: output rows 1,3,5,...; replays the line buffer, accepts no input.
- ROW_EVEN:
  - in_ready = 1 when the holding register is empty, or when it holds the second copy (dup=1) and out_ready=1. Otherwise 0.
  - On an input transfer: write in_data to linebuf[col], load the holding register, out_valid=1, dup=0.
  - On an output transfer with dup=0: dup becomes 1 and out_data is unchanged.
  - On an output transfer with dup=1: col increments. If col was InputW/2-1, col clears and the FSM goes to ROW_ODD.
- ROW_ODD:
  - in_ready = 0.
  - The holding register loads linebuf[col] whenever it is empty or its second copy is transferring; each entry is emitted twice.
  - After the second copy of entry InputW/2-1: col clears and prow increments. If prow was InputH/2-1, prow clears and the FSM goes to ROW_EVEN. Otherwise it also goes to ROW_EVEN.
- out_last = 1 only on the second copy of linebuf[InputW/2-1] in ROW_ODD when prow = InputH/2-1.
- Latency: input transfer at cycle N gives out_valid=1 at cycle N+1.
- Throughput: 1 output per cycle with out_ready held high. Peak input rate is 1 pixel per 2 cycles in ROW_EVEN, 0 in ROW_ODD.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and dup hold stable, and in_ready=0.
- Frames: back-to-back frames need no gap; the first pixel of the next frame may transfer in the same cycle the out_last pixel transfers.
- Reset values: out_valid=0, out_data=0, out_last=0, dup=0, col=0, prow=0, state ROW_EVEN. in_ready=0 while reset=0.
- Line buffer is not cleared by reset; its contents are don't-care.
- Reset mid-frame discards the partial frame. The first transfer after release is pixel (0,0) of a new frame.
- No internal error detection. Input count is implied by the handshake, so no overrun is possible.

Optional Feature:
- Macro: UNPOOL_ZERO_FILL_EN.
- Defined: zero-insertion unpooling.
  - ROW_EVEN, dup=0 outputs in_data; dup=1 outputs 0.
  - ROW_ODD outputs 0 for both copies.
  - Timing, handshakes and out_last are unchanged.
  - The line buffer is not instantiated; ROW_ODD still runs InputW cycles of zeros.
- Undefined: nearest-neighbour replication as described in Behaviour.

Test Plan:
- InputH=InputW=4, inputs 1,2,3,4, out_ready=1 -> outputs 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4; out_last only on the 16th output; in_ready low for 4 cycles after each 2 inputs.
- Same map with out_ready toggling 1,0 each cycle -> identical output sequence; out_data stable during every ready=0 cycle; no dropped or duplicated outputs.
- Two frames back-to-back (1..4 then 5..8), in_valid held high -> 32 outputs, second frame 5,5,6,6,5,5,6,6,7,7,8,8,7,7,8,8; no idle cycle between frames; out_last on outputs 16 and 32.
- Reset low for 1 cycle after the 6th output of frame 1 -> out_valid=0 next cycle; new frame 9,10,11,12 gives 9,9,10,10,9,9,10,10,...; no stale data.
- With UNPOOL_ZERO_FILL_EN, inputs 1,2,3,4 -> 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0; out_last on the 16th output.
- Default 28x28, 196 random inputs, random out_ready -> 784 outputs matching the reference-model replication; exactly one out_last.
